// File: rtl/alu_reservation_station_if.sv
// ----------------------------------------------------------------------------
// alu_reservation_station_if
// Bundles the reservation station's bus signals: global control (en, flush),
// the issue port (iss_*), the ALU common data bus snoop (cdb_*), the
// occupancy flag (full_o) and the dispatch port into the ALU (alu_*).
//   slave  : the reservation station. It consumes issue/CDB/control and
//            drives full_o and alu_*.
//   master : the environment. It drives issue/CDB/control and observes the
//            outputs.
// clk and rst_n are not part of the bundle; they stay plain module ports.
// ----------------------------------------------------------------------------
interface alu_reservation_station_if #(
    parameter int ROB_BIT = 4,
    parameter int DAT_W   = 32,
    parameter int OP_W    = 6,
    parameter int ADR_W   = 17
);
    // Global control
    logic               en;
    logic               flush;

    // Issue port
    logic               iss_en_i;
    logic [OP_W-1:0]    iss_op_i;
    logic               iss_ic_i;
    logic [ROB_BIT-1:0] iss_qd_i;
    logic               iss_rs_i;
    logic [ROB_BIT-1:0] iss_qs_i;
    logic [DAT_W-1:0]   iss_vs_i;
    logic               iss_rt_i;
    logic [ROB_BIT-1:0] iss_qt_i;
    logic [DAT_W-1:0]   iss_vt_i;
    logic [DAT_W-1:0]   iss_imm_i;
    logic [ADR_W-1:0]   iss_pc_i;
    logic               full_o;

    // ALU CDB snoop
    logic               cdb_en_i;
    logic [ROB_BIT-1:0] cdb_q_i;
    logic [DAT_W-1:0]   cdb_v_i;

    // Dispatch port
    logic               alu_en_o;
    logic [OP_W-1:0]    alu_op_o;
    logic               alu_ic_o;
    logic [ROB_BIT-1:0] alu_qd_o;
    logic [DAT_W-1:0]   alu_vs_o;
    logic [DAT_W-1:0]   alu_vt_o;
    logic [DAT_W-1:0]   alu_imm_o;
    logic [ADR_W-1:0]   alu_pc_o;

    modport slave (
        input  en, flush,
        input  iss_en_i, iss_op_i, iss_ic_i, iss_qd_i,
        input  iss_rs_i, iss_qs_i, iss_vs_i,
        input  iss_rt_i, iss_qt_i, iss_vt_i,
        input  iss_imm_i, iss_pc_i,
        output full_o,
        input  cdb_en_i, cdb_q_i, cdb_v_i,
        output alu_en_o, alu_op_o, alu_ic_o, alu_qd_o,
        output alu_vs_o, alu_vt_o, alu_imm_o, alu_pc_o
    );

    modport master (
        output en, flush,
        output iss_en_i, iss_op_i, iss_ic_i, iss_qd_i,
        output iss_rs_i, iss_qs_i, iss_vs_i,
        output iss_rt_i, iss_qt_i, iss_vt_i,
        output iss_imm_i, iss_pc_i,
        input  full_o,
        output cdb_en_i, cdb_q_i, cdb_v_i,
        input  alu_en_o, alu_op_o, alu_ic_o, alu_qd_o,
        input  alu_vs_o, alu_vt_o, alu_imm_o, alu_pc_o
    );
endinterface

// File: rtl/alu_reservation_station.sv
// ----------------------------------------------------------------------------
// alu_reservation_station
// Buffers decoded ALU/branch/jump instructions until both operands are known,
// snoops the ALU CDB to wake pending operands, and dispatches at most one ready
// instruction per cycle into the ALU.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset (drops every entry and the
//            dispatch register)
//   bus    : alu_reservation_station_if.slave carrying en/flush, issue
//            port, CDB snoop, full_o and the registered alu_* dispatch port
// Readiness is purely flag based; ROB tag 0 is an ordinary tag.
// ----------------------------------------------------------------------------
module alu_reservation_station #(
    parameter int RS_SIZE = 8,
    parameter int RS_BIT  = 3,
    parameter int ROB_BIT = 4,
    parameter int DAT_W   = 32,
    parameter int OP_W    = 6,
    parameter int ADR_W   = 17
) (
    input  logic                        clk,
    input  logic                        rst_n,
    alu_reservation_station_if.slave    bus
);

    // Entry storage
    logic [RS_SIZE-1:0] busy_r;
    logic [RS_SIZE-1:0] rs_r;
    logic [RS_SIZE-1:0] rt_r;
    logic [RS_SIZE-1:0] ic_r;
    logic [OP_W-1:0]    op_r  [RS_SIZE];
    logic [ROB_BIT-1:0] qd_r  [RS_SIZE];
    logic [ROB_BIT-1:0] qs_r  [RS_SIZE];
    logic [ROB_BIT-1:0] qt_r  [RS_SIZE];
    logic [DAT_W-1:0]   vs_r  [RS_SIZE];
    logic [DAT_W-1:0]   vt_r  [RS_SIZE];
    logic [DAT_W-1:0]   imm_r [RS_SIZE];
    logic [ADR_W-1:0]   pc_r  [RS_SIZE];

    // Registered dispatch port
    logic               alu_en_r;
    logic [OP_W-1:0]    alu_op_r;
    logic               alu_ic_r;
    logic [ROB_BIT-1:0] alu_qd_r;
    logic [DAT_W-1:0]   alu_vs_r;
    logic [DAT_W-1:0]   alu_vt_r;
    logic [DAT_W-1:0]   alu_imm_r;
    logic [ADR_W-1:0]   alu_pc_r;

    // Combinational selection / wakeup
    logic [RS_SIZE-1:0] ready_s;
    logic [RS_SIZE-1:0] wake_s_s;
    logic [RS_SIZE-1:0] wake_t_s;
    logic [RS_BIT-1:0]  free_idx_s;
    logic [RS_BIT-1:0]  disp_idx_s;
    logic               disp_vld_s;
    logic               full_s;
    logic               issue_s;
    logic               fwd_s_s;
    logic               fwd_t_s;

    assign full_s  = &busy_r;
    assign ready_s = busy_r & rs_r & rt_r;

    // Lowest free slot, lowest ready slot, and per-entry CDB tag matches
    always_comb begin
        free_idx_s = {RS_BIT{1'b0}};
        disp_idx_s = {RS_BIT{1'b0}};
        wake_s_s   = {RS_SIZE{1'b0}};
        wake_t_s   = {RS_SIZE{1'b0}};
        // Walking downwards leaves the lowest matching index in place.
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            free_idx_s = busy_r[i]  ? free_idx_s : RS_BIT'(i);
            disp_idx_s = ready_s[i] ? RS_BIT'(i) : disp_idx_s;
        end
        for (int i = 0; i < RS_SIZE; i++) begin
            wake_s_s[i] = busy_r[i] & ~rs_r[i] & bus.cdb_en_i & (qs_r[i] == bus.cdb_q_i);
            wake_t_s[i] = busy_r[i] & ~rt_r[i] & bus.cdb_en_i & (qt_r[i] == bus.cdb_q_i);
        end
    end

    assign disp_vld_s = |ready_s;
    assign issue_s    = bus.iss_en_i & ~full_s;
    // A same-cycle broadcast satisfies an operand that arrives not ready.
    assign fwd_s_s    = ~bus.iss_rs_i & bus.cdb_en_i & (bus.iss_qs_i == bus.cdb_q_i);
    assign fwd_t_s    = ~bus.iss_rt_i & bus.cdb_en_i & (bus.iss_qt_i == bus.cdb_q_i);

    // Entry state and dispatch register: reset, flush, then enabled update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r    <= {RS_SIZE{1'b0}};
            rs_r      <= {RS_SIZE{1'b0}};
            rt_r      <= {RS_SIZE{1'b0}};
            ic_r      <= {RS_SIZE{1'b0}};
            for (int i = 0; i < RS_SIZE; i++) begin
                op_r[i]  <= {OP_W{1'b0}};
                qd_r[i]  <= {ROB_BIT{1'b0}};
                qs_r[i]  <= {ROB_BIT{1'b0}};
                qt_r[i]  <= {ROB_BIT{1'b0}};
                vs_r[i]  <= {DAT_W{1'b0}};
                vt_r[i]  <= {DAT_W{1'b0}};
                imm_r[i] <= {DAT_W{1'b0}};
                pc_r[i]  <= {ADR_W{1'b0}};
            end
            alu_en_r  <= 1'b0;
            alu_op_r  <= {OP_W{1'b0}};
            alu_ic_r  <= 1'b0;
            alu_qd_r  <= {ROB_BIT{1'b0}};
            alu_vs_r  <= {DAT_W{1'b0}};
            alu_vt_r  <= {DAT_W{1'b0}};
            alu_imm_r <= {DAT_W{1'b0}};
            alu_pc_r  <= {ADR_W{1'b0}};
        end else if (bus.flush) begin
            // Flush does not wait for en: a misprediction must clear the window.
            busy_r    <= {RS_SIZE{1'b0}};
            alu_en_r  <= 1'b0;
            alu_op_r  <= {OP_W{1'b0}};
            alu_ic_r  <= 1'b0;
            alu_qd_r  <= {ROB_BIT{1'b0}};
            alu_vs_r  <= {DAT_W{1'b0}};
            alu_vt_r  <= {DAT_W{1'b0}};
            alu_imm_r <= {DAT_W{1'b0}};
            alu_pc_r  <= {ADR_W{1'b0}};
        end else if (bus.en) begin
            // Wakeup of waiting operands on busy entries
            for (int i = 0; i < RS_SIZE; i++) begin
                if (wake_s_s[i]) begin
                    rs_r[i] <= 1'b1;
                    vs_r[i] <= bus.cdb_v_i;
                end
                if (wake_t_s[i]) begin
                    rt_r[i] <= 1'b1;
                    vt_r[i] <= bus.cdb_v_i;
                end
            end

            // Dispatch uses readiness as registered at cycle start, so a
            // woken entry leaves one edge after its broadcast.
            if (disp_vld_s) begin
                alu_en_r           <= 1'b1;
                alu_op_r           <= op_r[disp_idx_s];
                alu_ic_r           <= ic_r[disp_idx_s];
                alu_qd_r           <= qd_r[disp_idx_s];
                alu_vs_r           <= vs_r[disp_idx_s];
                alu_vt_r           <= vt_r[disp_idx_s];
                alu_imm_r          <= imm_r[disp_idx_s];
                alu_pc_r           <= pc_r[disp_idx_s];
                busy_r[disp_idx_s] <= 1'b0;
            end else begin
                alu_en_r  <= 1'b0;
                alu_op_r  <= {OP_W{1'b0}};
                alu_ic_r  <= 1'b0;
                alu_qd_r  <= {ROB_BIT{1'b0}};
                alu_vs_r  <= {DAT_W{1'b0}};
                alu_vt_r  <= {DAT_W{1'b0}};
                alu_imm_r <= {DAT_W{1'b0}};
                alu_pc_r  <= {ADR_W{1'b0}};
            end

            // Issue targets a slot that was free at cycle start, so it never
            // collides with the dispatched or woken entries.
            if (issue_s) begin
                busy_r[free_idx_s] <= 1'b1;
                op_r[free_idx_s]   <= bus.iss_op_i;
                ic_r[free_idx_s]   <= bus.iss_ic_i;
                qd_r[free_idx_s]   <= bus.iss_qd_i;
                qs_r[free_idx_s]   <= bus.iss_qs_i;
                qt_r[free_idx_s]   <= bus.iss_qt_i;
                rs_r[free_idx_s]   <= bus.iss_rs_i | fwd_s_s;
                rt_r[free_idx_s]   <= bus.iss_rt_i | fwd_t_s;
                vs_r[free_idx_s]   <= fwd_s_s ? bus.cdb_v_i : bus.iss_vs_i;
                vt_r[free_idx_s]   <= fwd_t_s ? bus.cdb_v_i : bus.iss_vt_i;
                imm_r[free_idx_s]  <= bus.iss_imm_i;
                pc_r[free_idx_s]   <= bus.iss_pc_i;
            end
        end else begin
            // en low: the whole pipeline is frozen, everything holds.
            busy_r <= busy_r;
        end
    end

    assign bus.full_o    = full_s;
    assign bus.alu_en_o  = alu_en_r;
    assign bus.alu_op_o  = alu_op_r;
    assign bus.alu_ic_o  = alu_ic_r;
    assign bus.alu_qd_o  = alu_qd_r;
    assign bus.alu_vs_o  = alu_vs_r;
    assign bus.alu_vt_o  = alu_vt_r;
    assign bus.alu_imm_o = alu_imm_r;
    assign bus.alu_pc_o  = alu_pc_r;

endmodule
